// File: rtl/subadd_rr_arbiter.sv
// subadd_rr_arbiter: shares one 5-bit add/subtract datapath between two
// requesters (ch0, ch1) with round-robin arbitration. Each accepted request
// moves through IDLE -> EXEC -> RESP and returns a registered result tagged
// with the requester id.
//
// Optional build macro SUBADD_ARB_STATS_EN: adds per-channel saturating
// counters (op_cnt0/op_cnt1) of completed result handshakes.
module subadd_rr_arbiter #(
  parameter bit PRIO_INIT = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in0_valid,
  output logic       in0_ready,
  input  logic [4:0] in0_a,
  input  logic [4:0] in0_b,
  input  logic       in0_mode,
  input  logic       in1_valid,
  output logic       in1_ready,
  input  logic [4:0] in1_a,
  input  logic [4:0] in1_b,
  input  logic       in1_mode,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_id,
  output logic [4:0] out_sum,
  output logic       out_cout,
  output logic       out_ovf
`ifdef SUBADD_ARB_STATS_EN
  ,
  output logic [7:0] op_cnt0,
  output logic [7:0] op_cnt1
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e     state_q;
  logic       ptr_q;       // channel that wins when both are valid
  logic [4:0] op_a_q;
  logic [4:0] op_b_q;
  logic       op_mode_q;
  logic       op_id_q;

  logic       out_valid_q;
  logic       out_id_q;
  logic [4:0] out_sum_q;
  logic       out_cout_q;
  logic       out_ovf_q;

  logic [4:0] y_d;
  logic [5:0] sum_full_d;
  logic       ovf_d;

  // Grant: single valid wins outright, the pointer breaks ties; only in IDLE.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    in0_ready = 1'b0;
    in1_ready = 1'b0;
    if (state_q == IDLE) begin
      if (in0_valid && (!in1_valid || (ptr_q == 1'b0))) begin
        in0_ready = 1'b1;
      end else if (in1_valid) begin
        in1_ready = 1'b1;
      end
    end
  end

  // Shared datapath: subtract is a + ~b + 1, so cout = 1 means no borrow.
  always_comb begin
    y_d        = op_b_q ^ {5{op_mode_q}};
    sum_full_d = {1'b0, op_a_q} + {1'b0, y_d} + {5'd0, op_mode_q};
    ovf_d      = (op_a_q[4] == y_d[4]) && (sum_full_d[4] != op_a_q[4]);
  end

  // Sequencer: accept, compute, then hold the result until it is consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= PRIO_INIT;
      // NOTE: operand registers are reset too; they are few and this keeps
      // the datapath free of X after reset.
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_mode_q   <= 1'b0;
      op_id_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_id_q    <= 1'b0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (state_q)
        IDLE: begin
          if (in0_valid && in0_ready) begin
            op_a_q    <= in0_a;
            op_b_q    <= in0_b;
            op_mode_q <= in0_mode;
            op_id_q   <= 1'b0;
            ptr_q     <= 1'b1;
            state_q   <= EXEC;
          end else if (in1_valid && in1_ready) begin
            op_a_q    <= in1_a;
            op_b_q    <= in1_b;
            op_mode_q <= in1_mode;
            op_id_q   <= 1'b1;
            ptr_q     <= 1'b0;
            state_q   <= EXEC;
          end
        end
        EXEC: begin
          out_sum_q   <= sum_full_d[4:0];
          out_cout_q  <= sum_full_d[5];
          out_ovf_q   <= ovf_d;
          out_id_q    <= op_id_q;
          out_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_id    = out_id_q;
  assign out_sum   = out_sum_q;
  assign out_cout  = out_cout_q;
  assign out_ovf   = out_ovf_q;

`ifdef SUBADD_ARB_STATS_EN
  logic [7:0] op_cnt0_q;
  logic [7:0] op_cnt1_q;

  // Count completed result handshakes per channel, saturating at 255.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_cnt0_q <= '0;
      op_cnt1_q <= '0;
    end else if (out_valid_q && out_ready) begin
      if (!out_id_q && (op_cnt0_q != 8'hFF)) op_cnt0_q <= op_cnt0_q + 8'd1;
      if (out_id_q && (op_cnt1_q != 8'hFF))  op_cnt1_q <= op_cnt1_q + 8'd1;
    end
  end

  assign op_cnt0 = op_cnt0_q;
  assign op_cnt1 = op_cnt1_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
